// File: rtl/sd_sector_ctrl.sv
// Sector transfer controller between a core-side 512-byte buffer and the user_io SD
// handshake (sd_rd/sd_wr, sd_ack), with request timeout and a dual-port byte buffer.
module sd_sector_ctrl #(
  parameter logic [23:0] TIMEOUT = 24'd12000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  // core request side
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_lba,
  output logic        busy,
  output logic        done,
  output logic        err,
  // core buffer port
  input  logic [8:0]  core_addr,
  input  logic [7:0]  core_wdata,
  input  logic        core_we,
  output logic [7:0]  core_rdata,
  // user_io SD side
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_dout,
  input  logic        sd_dout_strobe,
  output logic [7:0]  sd_din,
  input  logic        sd_din_strobe
);

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LBA_W  = 32;
  localparam int unsigned CNT_W  = 24;
  localparam int unsigned DEPTH  = 512;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER
  } state_e;

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [LBA_W-1:0]   lba_q, lba_d;
  logic               sd_rd_q, sd_rd_d;
  logic               sd_wr_q, sd_wr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ack_q, ack_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [DATA_W-1:0]  core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0]  sd_din_q, sd_din_d;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               core_wr_en;
  logic               sd_wr_en;
  logic               unused_sd_din_strobe;

  // sd_din_strobe is informational only; the buffer is read every cycle regardless
  assign unused_sd_din_strobe = sd_din_strobe;

  // State register and registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      lba_q   <= '0;
      sd_rd_q <= 1'b0;
      sd_wr_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      lba_q   <= lba_d;
      sd_rd_q <= sd_rd_d;
      sd_wr_q <= sd_wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    lba_d   = lba_q;
    sd_rd_d = sd_rd_q;
    sd_wr_d = sd_wr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ack_d   = sd_ack;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        // read has priority when both requests arrive together
        if (req_rd || req_wr) begin
          state_d = ST_REQ;
          lba_d   = req_lba;
          dir_d   = ~req_rd;
          sd_rd_d = req_rd;
          sd_wr_d = ~req_rd;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        if (sd_ack) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT) begin
            sd_rd_d = 1'b0;
            sd_wr_d = 1'b0;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_XFER: begin
        if (ack_q && !sd_ack) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sd_rd_d = 1'b0;
        sd_wr_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Buffer write enables: core only while idle, SD only during a read transfer
  assign core_wr_en = core_we && (state_q == ST_IDLE);
  assign sd_wr_en   = sd_dout_strobe && (state_q == ST_XFER) && !dir_q;

  // Buffer storage; the two writers are never enabled in the same state
  always_ff @(posedge clk_sys) begin
    if (core_wr_en) begin
      mem[core_addr] <= core_wdata;
    end
    if (sd_wr_en) begin
      mem[sd_buff_addr] <= sd_dout;
    end
  end

  always_comb begin
    core_rdata_d = mem[core_addr];
    sd_din_d     = mem[sd_buff_addr];
  end

  // Registered read ports
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      core_rdata_q <= '0;
      sd_din_q     <= '0;
    end else begin
      core_rdata_q <= core_rdata_d;
      sd_din_q     <= sd_din_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign core_rdata = core_rdata_q;
  assign sd_lba     = lba_q;
  assign sd_rd      = sd_rd_q;
  assign sd_wr      = sd_wr_q;
  assign sd_din     = sd_din_q;

  localparam int unsigned ADDR_W_CHK = ADDR_W;

endmodule

// File: tb/tb_sd_sector_ctrl.sv
// Directed self-checking bench for sd_sector_ctrl: read, write, timeout, collisions, reset.
module tb_sd_sector_ctrl;

  logic        clk_sys;
  logic        reset;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] req_lba;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  core_addr;
  logic [7:0]  core_wdata;
  logic        core_we;
  logic [7:0]  core_rdata;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_dout;
  logic        sd_dout_strobe;
  logic [7:0]  sd_din;
  logic        sd_din_strobe;

  int tests_run;
  int tests_failed;

  sd_sector_ctrl #(.TIMEOUT(24'd100)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .req_rd         (req_rd),
    .req_wr         (req_wr),
    .req_lba        (req_lba),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_we        (core_we),
    .core_rdata     (core_rdata),
    .sd_lba         (sd_lba),
    .sd_rd          (sd_rd),
    .sd_wr          (sd_wr),
    .sd_ack         (sd_ack),
    .sd_buff_addr   (sd_buff_addr),
    .sd_dout        (sd_dout),
    .sd_dout_strobe (sd_dout_strobe),
    .sd_din         (sd_din),
    .sd_din_strobe  (sd_din_strobe)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({sd_rd, sd_wr, busy, done, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 00000", {sd_rd, sd_wr, busy, done, err});
    end
    tests_run++;
    if (sd_lba !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_lba: got %h expected 00000000", sd_lba);
    end
    tests_run++;
    if ({sd_din, core_rdata} !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected 0000", {sd_din, core_rdata});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read();
    int done_cnt;
    req_rd  = 1'b1;
    req_lba = 32'h0000_1234;
    tick();
    req_rd  = 1'b0;
    tests_run++;
    if ({sd_lba, sd_rd, sd_wr, busy} !== {32'h0000_1234, 3'b101}) begin
      tests_failed++;
      $display("FAIL read_req: got lba=%h rd=%b wr=%b busy=%b expected 00001234 1 0 1",
               sd_lba, sd_rd, sd_wr, busy);
    end
    sd_ack = 1'b1;
    tick();
    tests_run++;
    if ({sd_rd, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL read_ack_drop: got rd=%b busy=%b expected 0 1", sd_rd, busy);
    end
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr   = 9'(i);
      sd_dout        = 8'(i);
      sd_dout_strobe = 1'b1;
      tick();
    end
    sd_dout_strobe = 1'b0;
    sd_ack = 1'b0;
    done_cnt = 0;
    tick();
    tests_run++;
    if ({done, busy, err} !== 3'b100) begin
      tests_failed++;
      $display("FAIL read_done: got done=%b busy=%b err=%b expected 1 0 0", done, busy, err);
    end
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      tick();
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL read_done_once: got %0d pulses expected 1", done_cnt);
    end
    core_addr = 9'h101;
    tick();
    tests_run++;
    if (core_rdata !== 8'h01) begin
      tests_failed++;
      $display("FAIL read_core_101: got %h expected 01", core_rdata);
    end
    core_addr = 9'h0FE;
    tick();
    tests_run++;
    if (core_rdata !== 8'hFE) begin
      tests_failed++;
      $display("FAIL read_core_0fe: got %h expected fe", core_rdata);
    end
  endtask

  task automatic test_write();
    int bad;
    for (int i = 0; i < 512; i++) begin
      core_addr  = 9'(i);
      core_wdata = 8'(i) ^ 8'h5A;
      core_we    = 1'b1;
      tick();
    end
    core_we = 1'b0;
    req_wr  = 1'b1;
    req_lba = 32'h00AB_CDEF;
    tick();
    req_wr  = 1'b0;
    tests_run++;
    if ({sd_lba, sd_rd, sd_wr, busy} !== {32'h00AB_CDEF, 3'b011}) begin
      tests_failed++;
      $display("FAIL write_req: got lba=%h rd=%b wr=%b busy=%b expected 00abcdef 0 1 1",
               sd_lba, sd_rd, sd_wr, busy);
    end
    sd_ack = 1'b1;
    tick();
    tests_run++;
    if (sd_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_ack_drop: got %b expected 0", sd_wr);
    end
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      sd_buff_addr = 9'(i);
      tick();
      if (sd_din !== (8'(i) ^ 8'h5A)) begin
        if (bad < 4) $display("FAIL write_din[%0d]: got %h expected %h", i, sd_din, 8'(i) ^ 8'h5A);
        bad++;
      end
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL write_din_total: got %0d bad bytes expected 0", bad);
    end
    sd_ack = 1'b0;
    tick();
    tests_run++;
    if ({done, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL write_done: got done=%b busy=%b expected 1 0", done, busy);
    end
    tick();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_timeout();
    int k;
    logic rd_before;
    req_rd  = 1'b1;
    req_lba = 32'h0000_0042;
    tick();
    req_rd = 1'b0;
    k = 0;
    rd_before = 1'b0;
    for (int i = 1; i <= 150; i++) begin
      rd_before = sd_rd;
      tick();
      if (err) begin
        k = i;
        break;
      end
    end
    tests_run++;
    if (k !== 100) begin
      tests_failed++;
      $display("FAIL timeout_cycles: got %0d expected 100", k);
    end
    tests_run++;
    if ({rd_before, sd_rd, busy, done} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL timeout_state: got rd_before=%b rd=%b busy=%b done=%b expected 1 0 0 0",
               rd_before, sd_rd, busy, done);
    end
    tick();
    tests_run++;
    if ({err, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL timeout_err_pulse: got err=%b busy=%b expected 0 0", err, busy);
    end
  endtask

  task automatic test_collision();
    req_rd  = 1'b1;
    req_wr  = 1'b1;
    req_lba = 32'h0000_5555;
    tick();
    req_rd = 1'b0;
    req_wr = 1'b0;
    tests_run++;
    if ({sd_rd, sd_wr} !== 2'b10) begin
      tests_failed++;
      $display("FAIL coll_rd_wins: got rd=%b wr=%b expected 1 0", sd_rd, sd_wr);
    end
    sd_ack = 1'b1;
    tick();
    req_wr  = 1'b1;
    req_lba = 32'h0000_DEAD;
    tick();
    req_wr = 1'b0;
    tests_run++;
    if ({sd_lba, sd_wr, busy} !== {32'h0000_5555, 2'b01}) begin
      tests_failed++;
      $display("FAIL coll_wr_in_xfer: got lba=%h wr=%b busy=%b expected 00005555 0 1",
               sd_lba, sd_wr, busy);
    end
    core_addr  = 9'd5;
    core_wdata = 8'hEE;
    core_we    = 1'b1;
    tick();
    core_we = 1'b0;
    sd_ack  = 1'b0;
    tick();
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL coll_done: got %b expected 1", done);
    end
    tick();
    tests_run++;
    if (core_rdata !== 8'h5F) begin
      tests_failed++;
      $display("FAIL coll_core_we_ignored: got %h expected 5f", core_rdata);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int pulses;
    core_addr  = 9'd200;
    core_wdata = 8'h33;
    core_we    = 1'b1;
    tick();
    core_we = 1'b0;
    req_rd  = 1'b1;
    req_lba = 32'h0000_0077;
    tick();
    req_rd = 1'b0;
    sd_ack = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      sd_buff_addr   = 9'(i);
      sd_dout        = 8'hA5;
      sd_dout_strobe = 1'b1;
      tick();
    end
    sd_dout_strobe = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if ({sd_rd, sd_wr, busy, done, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL rst_xfer_ctrl: got %b expected 00000", {sd_rd, sd_wr, busy, done, err});
    end
    sd_buff_addr   = 9'd200;
    sd_dout        = 8'h11;
    sd_dout_strobe = 1'b1;
    tick();
    sd_dout_strobe = 1'b0;
    sd_ack = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || err || busy) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL rst_xfer_no_pulse: got %0d active cycles expected 0", pulses);
    end
    core_addr = 9'd200;
    tick();
    tests_run++;
    if (core_rdata !== 8'h33) begin
      tests_failed++;
      $display("FAIL rst_xfer_strobe_ignored: got %h expected 33", core_rdata);
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b1;
    req_rd         = 1'b0;
    req_wr         = 1'b0;
    req_lba        = '0;
    core_addr      = '0;
    core_wdata     = '0;
    core_we        = 1'b0;
    sd_ack         = 1'b0;
    sd_buff_addr   = '0;
    sd_dout        = '0;
    sd_dout_strobe = 1'b0;
    sd_din_strobe  = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_collision();
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sd_sector_ctrl.md
SD_SECTOR_CTRL -- requirements
Module: sd_sector_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 24'd12000000, maximum clk_sys cycles to wait for sd_ack rising after a request.
REQ-002 clk_sys  in  1  single clock; all ports synchronous to its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_rd  in  1  core pulse: read sector req_lba into the buffer.
REQ-005 req_wr  in  1  core pulse: write the buffer to sector req_lba.
REQ-006 req_lba  in  32  sector number, sampled on an accepted request.
REQ-007 busy  out  1  high whenever the state is not IDLE.
REQ-008 done  out  1  one-cycle pulse when a transfer completes.
REQ-009 err  out  1  one-cycle pulse on timeout.
REQ-010 core_addr  in  9  core buffer address.
REQ-011 core_wdata  in  8  core write data.
REQ-012 core_we  in  1  core buffer write strobe.
REQ-013 core_rdata  out  8  buffer byte at core_addr, registered.
REQ-014 sd_lba  out  32  sector number to user_io.
REQ-015 sd_rd  out  1  read request to user_io.
REQ-016 sd_wr  out  1  write request to user_io.
REQ-017 sd_ack  in  1  high while the IO controller services the request.
REQ-018 sd_buff_addr  in  9  transfer byte index from user_io.
REQ-019 sd_dout  in  8  read data from user_io.
REQ-020 sd_dout_strobe  in  1  sd_dout valid, written at sd_buff_addr.
REQ-021 sd_din  out  8  write data to user_io.
REQ-022 sd_din_strobe  in  1  user_io consumed a byte (monitor only).
REQ-023 user_io clk_sd is tied to clk_sys, so all sd_* signals are in the clk_sys domain.

Function
REQ-024 Storage: one 512x8 buffer with two ports.
- Port A is the core port: write on core_we; core_rdata = buf[core_addr] one cycle after core_addr is presented.
- Port B is the SD port: write on sd_dout_strobe; sd_din = buf[sd_buff_addr] registered every cycle, with 1-cycle latency.
REQ-025 FSM states: IDLE, REQ, XFER.
- An internal dir bit records the request type: 0 = read, 1 = write.
REQ-026 IDLE -> REQ on req_rd or req_wr.
- Latch sd_lba <= req_lba.
- dir <= ~req_rd.
- Clear the timeout counter.
- If req_rd and req_wr arrive together, the read wins and req_wr is dropped.
REQ-027 REQ state:
- sd_rd = ~dir and sd_wr = dir, both held high.
- On sd_ack = 1, deassert both requests in that same cycle's registered update and move to XFER.
REQ-028 REQ timeout: when the counter reaches TIMEOUT with sd_ack still low:
- drop sd_rd and sd_wr;
- pulse err for 1 cycle;
- return to IDLE.
REQ-029 XFER exits when sd_ack falls (1 -> 0 across consecutive cycles): pulse done for 1 cycle, then go to IDLE.
- XFER has no timeout.
REQ-030 sd_dout_strobe writes the buffer only in XFER with dir = 0; it is ignored otherwise.
REQ-031 core_we writes the buffer only when busy = 0; it is ignored while busy.
- core_rdata stays readable at all times.
REQ-032 req_rd and req_wr are ignored while busy, with no queuing.
REQ-033 sd_lba holds its latched value until the next accepted request.
REQ-034 The timeout counter is 24 bits and saturates; it does not wrap.
REQ-035 The done and err pulses never coincide.

Reset
REQ-036 Reset values: state IDLE, sd_rd = 0, sd_wr = 0, busy = 0, done = 0, err = 0, sd_lba = 0, sd_din = 0, core_rdata = 0, timeout counter = 0.
REQ-037 Reset mid-transfer:
- drops sd_rd and sd_wr the next cycle;
- produces no done or err pulse;
- leaves buffer contents unchanged and unspecified;
- any later sd_dout_strobe is ignored until a new read request.

Verification
REQ-038 Read: req_rd with req_lba = 0x00001234 -> sd_lba = 0x1234 and sd_rd = 1. Drive sd_ack high, then 512 strobes writing 0x00..0xFF twice, then sd_ack low -> done pulse once; core reads addr 0x101 -> 0x01 one cycle later.
REQ-039 Write: core fills buf[i] = i^0x5A, then req_wr -> sd_wr = 1. Drive sd_ack high and step sd_buff_addr 0..511 -> sd_din = i^0x5A one cycle after each address; done pulses on sd_ack fall.
REQ-040 Timeout: TIMEOUT = 100, req_rd with sd_ack held low -> sd_rd drops and err pulses exactly 100 cycles after entering REQ; busy = 0 afterwards.
REQ-041 Collisions: req_rd and req_wr in the same cycle -> only sd_rd asserted. req_wr during XFER -> ignored. core_we during XFER -> buffer unchanged.
REQ-042 Reset in XFER after 100 strobes -> sd_rd = sd_wr = 0 and busy = 0 the next cycle; no done pulse; a later sd_ack fall produces no pulse.
